// File: rtl/mic_cfg_pkg.sv
// Shared types and default widths for the mic-array configuration scheduler.
package mic_cfg_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int TMR_W  = 20;

  typedef struct packed {
    logic [3:0]        array;
    logic              bcast;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    NEXT
  } sched_state_t;

endpackage

// File: rtl/mic_cfg_fifo.sv
// Synchronous command FIFO; head entry is read straight from the storage registers.
module mic_cfg_fifo
  import mic_cfg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_data,
  input  logic             i_pop,
  output logic [CMD_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/mic_array_cfg_scheduler.sv
// Issues buffered register writes one at a time to the mic-array config controllers,
// walking enabled arrays for broadcasts and trapping controllers that never ack or finish.
//
//   state     | meaning
//   IDLE      | waiting for a command; pops FIFO head into cur
//   SELECT    | skip disabled/out-of-range target, wait for target not busy
//   ISSUE     | one-cycle start pulse to target, timer cleared
//   WAIT_ACK  | waiting for target busy to rise
//   WAIT_DONE | waiting for target busy to fall
//   NEXT      | advance broadcast index or finish
module mic_array_cfg_scheduler
  import mic_cfg_pkg::*;
#(
  parameter int NUM_ARRAYS   = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int ACK_TIMEOUT  = 64,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [3:0]            i_cmd_array,
  input  logic                  i_cmd_bcast,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [DATA_W-1:0]     i_cmd_data,
  input  logic [NUM_ARRAYS-1:0] i_array_en,
  input  logic [NUM_ARRAYS-1:0] i_arr_busy,
  output logic [NUM_ARRAYS-1:0] o_arr_start,
  output logic [ADDR_W-1:0]     o_arr_addr,
  output logic [DATA_W-1:0]     o_arr_data,
  output logic                  o_sched_idle,
  output logic                  o_err_flag,
  output logic [3:0]            o_err_array,
  input  logic                  i_err_clr,
  output logic [15:0]           o_done_count
);

  sched_state_t r_state, w_next;
  cmd_t         r_cur, w_in_cmd, w_head;
  logic [4:0]   r_idx;
  logic [TMR_W-1:0] r_tmr;
  logic         r_err_flag;
  logic [3:0]   r_err_array;
  logic [15:0]  r_done_count;

  logic w_full, w_empty, w_pop;
  logic w_sel_en, w_sel_busy, w_oob, w_last;
  logic w_ack_tmo, w_done_tmo;
  logic w_idx_inc, w_tmr_clr, w_tmr_inc, w_timeout, w_done;

  assign w_in_cmd = '{array: i_cmd_array, bcast: i_cmd_bcast, addr: i_cmd_addr, data: i_cmd_data};

  mic_cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_cmd_valid),
    .i_data  (w_in_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Index is one bit wider than the array field so out-of-range targets are representable.
  always_comb begin
    w_sel_en   = 1'b0;
    w_sel_busy = 1'b0;
    for (int i = 0; i < NUM_ARRAYS; i++) begin
      if (r_idx == 5'(i)) begin
        w_sel_en   = i_array_en[i];
        w_sel_busy = i_arr_busy[i];
      end
    end
  end

  assign w_oob      = (r_idx >= 5'(NUM_ARRAYS));
  assign w_last     = (r_idx == 5'(NUM_ARRAYS - 1));
  assign w_ack_tmo  = (r_tmr == TMR_W'(ACK_TIMEOUT - 1));
  assign w_done_tmo = (r_tmr == TMR_W'(DONE_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (!w_empty) w_next = SELECT;
      SELECT: begin
        if (w_oob || !w_sel_en) begin
          if (!r_cur.bcast || w_oob || w_last) w_next = IDLE;
        end else if (!w_sel_busy) begin
          w_next = ISSUE;
        end
      end
      ISSUE:     w_next = WAIT_ACK;
      WAIT_ACK:  if (w_sel_busy || w_ack_tmo) w_next = WAIT_DONE == WAIT_DONE && w_sel_busy ? WAIT_DONE : NEXT;
      WAIT_DONE: if (!w_sel_busy || w_done_tmo) w_next = NEXT;
      NEXT:      w_next = (!r_cur.bcast || w_last) ? IDLE : SELECT;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_pop       = 1'b0;
    w_idx_inc   = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_inc   = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    o_arr_start = '0;
    case (r_state)
      IDLE:   w_pop = !w_empty;
      SELECT: w_idx_inc = !w_oob && !w_sel_en && r_cur.bcast && !w_last;
      ISSUE: begin
        w_tmr_clr = 1'b1;
        for (int i = 0; i < NUM_ARRAYS; i++) o_arr_start[i] = (r_idx == 5'(i));
      end
      WAIT_ACK: begin
        if (w_sel_busy)     w_tmr_clr = 1'b1;
        else if (w_ack_tmo) w_timeout = 1'b1;
        else                w_tmr_inc = 1'b1;
      end
      WAIT_DONE: begin
        if (!w_sel_busy)     w_done    = 1'b1;
        else if (w_done_tmo) w_timeout = 1'b1;
        else                 w_tmr_inc = 1'b1;
      end
      NEXT:    w_idx_inc = r_cur.bcast && !w_last;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cur        <= '0;
      r_idx        <= '0;
      r_tmr        <= '0;
      r_err_flag   <= 1'b0;
      r_err_array  <= '0;
      r_done_count <= '0;
    end else begin
      if (w_pop) begin
        r_cur <= w_head;
        r_idx <= w_head.bcast ? 5'd0 : {1'b0, w_head.array};
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 5'd1;
      end
      if (w_tmr_clr)      r_tmr <= '0;
      else if (w_tmr_inc) r_tmr <= r_tmr + 1'b1;
      // First error is kept, but a timeout coinciding with a clear re-arms with the new index.
      if (w_timeout && (!r_err_flag || i_err_clr)) begin
        r_err_flag  <= 1'b1;
        r_err_array <= r_idx[3:0];
      end else if (i_err_clr) begin
        r_err_flag  <= 1'b0;
        r_err_array <= '0;
      end
      if (w_done) r_done_count <= r_done_count + 16'd1;
    end
  end

  assign o_cmd_ready  = !w_full;
  assign o_arr_addr   = r_cur.addr;
  assign o_arr_data   = r_cur.data;
  assign o_sched_idle = w_empty && (r_state == IDLE);
  assign o_err_flag   = r_err_flag;
  assign o_err_array  = r_err_array;
  assign o_done_count = r_done_count;

endmodule
